axi_mem_sched: RTL

Single-port memory access scheduler sitting between the subordinate's write handler / AR channel and its byte-wide memory array. Accepts whole-word write and read requests, arbitrates between them with two-way round-robin, and serialises each word into byte-lane memory accesses. Emits the write-completion pulse that enables the B channel and a held read word plus valid for the R channel.

---
 rtl/axi_mem_sched_pkg.sv | 32 +++
 rtl/axi_mem_sched_if.sv | 44 ++++
 rtl/axi_mem_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/axi_mem_sched_pkg.sv
// Shared types for the memory access scheduler:
// FSM states, grant encoding and the two-way round-robin pick.
package axi_mem_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD      = 3'd2,
        S_RD_LAST = 3'd3,
        S_RD_HOLD = 3'd4
    } sched_state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    // A tie goes to the side that did not win last time.
    function automatic grant_t rr_pick(
        input logic   wr,
        input logic   rd,
        input grant_t last
    );
        if (wr && rd)
            return (last == GRANT_WR) ? GRANT_RD : GRANT_WR;
        else if (rd)
            return GRANT_RD;
        else
            return GRANT_WR;
    endfunction

endpackage

// File: rtl/axi_mem_sched_if.sv
// Bundle between requesters, the scheduler and the byte-wide memory.
// slave: scheduler side; master: requesters plus the memory array.
interface axi_mem_sched_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rd_req, rd_addr, rd_ready,
        input  mem_rdata,
        output wr_ack, wr_done,
        output rd_ack, rd_valid, rd_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output wr_req, wr_addr, wr_data,
        output rd_req, rd_addr, rd_ready,
        output mem_rdata,
        input  wr_ack, wr_done,
        input  rd_ack, rd_valid, rd_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/axi_mem_sched.sv
// Single-port scheduler: round-robin between whole-word write/read
// requests, serialised into byte accesses on an external memory.
// Ports: ACLK, ARESET (async, active high), bus (slave modport):
//   wr_req/addr/data -> wr_ack, wr_done; rd_req/addr -> rd_ack,
//   rd_valid/rd_data held until rd_ready; mem_* byte port; busy.
module axi_mem_sched
    import axi_mem_sched_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic            ACLK,
    input  logic            ARESET,
    axi_mem_sched_if.slave  bus
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    sched_state_t      state_q, state_d;
    grant_t            grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    logic [CW-1:0]     cnt_nx;
    logic [CW-1:0]     cnt_pv;
    logic [ADDR_W-1:0] addr_nx;
    grant_t            pick;

    assign cnt_nx  = cnt_q + CW'(1);
    assign cnt_pv  = cnt_q - CW'(1);
    assign addr_nx = base_q + ADDR_W'(cnt_nx);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            grant_q     <= GRANT_WR;
            cnt_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            wr_ack_q    <= wr_ack_d;
            rd_ack_q    <= rd_ack_d;
            wr_done_q   <= wr_done_d;
            rd_valid_q  <= rd_valid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    // Outputs are computed one cycle ahead: the strobe for byte cnt
    // is on the bus while cnt_q == cnt.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        wr_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        wr_done_d   = 1'b0;
        rd_valid_d  = rd_valid_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        pick        = rr_pick(bus.wr_req, bus.rd_req, grant_q);

        unique case (state_q)
            S_IDLE: begin
                if (bus.wr_req || bus.rd_req) begin
                    grant_d  = pick;
                    cnt_d    = '0;
                    mem_en_d = 1'b1;
                    if (pick == GRANT_WR) begin
                        state_d     = S_WR;
                        wr_ack_d    = 1'b1;
                        base_d      = bus.wr_addr;
                        wdata_d     = bus.wr_data;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = bus.wr_addr;
                        mem_wdata_d = bus.wr_data[7:0];
                    end else begin
                        state_d    = S_RD;
                        rd_ack_d   = 1'b1;
                        base_d     = bus.rd_addr;
                        mem_addr_d = bus.rd_addr;
                    end
                end
            end
            S_WR: begin
                if (cnt_q == LAST) begin
                    state_d   = S_IDLE;
                    wr_done_d = 1'b1;
                end else begin
                    cnt_d       = cnt_nx;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_nx;
                    mem_wdata_d = wdata_q[8*cnt_nx +: 8];
                end
            end
            S_RD: begin
                // Read data trails its strobe by one cycle.
                if (cnt_q != '0)
                    rdata_d[8*cnt_pv +: 8] = bus.mem_rdata;
                if (cnt_q == LAST) begin
                    state_d = S_RD_LAST;
                end else begin
                    cnt_d      = cnt_nx;
                    mem_en_d   = 1'b1;
                    mem_addr_d = addr_nx;
                end
            end
            S_RD_LAST: begin
                rdata_d[DATA_W-1 -: 8] = bus.mem_rdata;
                rd_valid_d = 1'b1;
                state_d    = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule
